// File: rtl/accel_host_seq.sv
// Bus initiator for the accelerator peripheral. It takes 3-byte (op, A, B) command frames,
// runs the operand/opcode/commit register writes, reads the result and returns it.
module accel_host_seq #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic [3:0]  RES_ADDR   = 4'h5,
    parameter logic [3:0]  OP_ADDR    = 4'h4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic [3:0] bus_address,
    output logic       bus_data_write,
    output logic [7:0] bus_data_in,
    input  logic [7:0] bus_data_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, GET_A, GET_B, WR_A, WR_B, WR_OP, WR_COMMIT, GAP, RD_RES, RESP
    } state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    state_t     resume_q, resume_d;
    state_t     wr_next;
    logic [7:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;

    logic       cmd_ready_d;
    logic [3:0] bus_address_d;
    logic       bus_data_write_d;
    logic [7:0] bus_data_in_d;
    logic       rsp_valid_d;
    logic [7:0] rsp_data_d;
    logic       rsp_err_d;
    logic       busy_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        resume_d    = resume_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        wr_next     = RD_RES;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_data;
                    state_d = GET_A;
                end
            end
            GET_A: begin
                if (cmd_valid && cmd_ready) begin
                    a_d     = cmd_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (cmd_valid && cmd_ready) begin
                    b_d = cmd_data;
                    // An opcode with a non-zero upper nibble is rejected without touching the bus.
                    if (op_q[7:4] != 4'd0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 8'd0;
                    end else begin
                        state_d = WR_A;
                    end
                end
            end
            WR_A, WR_B, WR_OP, WR_COMMIT: begin
                case (state_q)
                    WR_A:    wr_next = WR_B;
                    WR_B:    wr_next = WR_OP;
                    WR_OP:   wr_next = WR_COMMIT;
                    default: wr_next = RD_RES;
                endcase
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    resume_d  = wr_next;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = wr_next;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) state_d = resume_q;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            RD_RES: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus_data_out;
                rsp_err_d   = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        cmd_ready_d      = (state_d == IDLE) || (state_d == GET_A) || (state_d == GET_B);
        busy_d           = (state_d != IDLE);
        bus_address_d    = 4'd0;
        bus_data_write_d = 1'b0;
        bus_data_in_d    = 8'd0;
        case (state_d)
            WR_A: begin
                bus_address_d    = 4'd0;
                bus_data_write_d = 1'b1;
                bus_data_in_d    = a_d;
            end
            WR_B: begin
                bus_address_d    = 4'd1;
                bus_data_write_d = 1'b1;
                bus_data_in_d    = b_d;
            end
            // The commit write repeats the opcode write; the peripheral latches its result on it.
            WR_OP, WR_COMMIT: begin
                bus_address_d    = OP_ADDR;
                bus_data_write_d = 1'b1;
                bus_data_in_d    = {4'b0, op_d[3:0]};
            end
            GAP: begin
                bus_address_d = bus_address;
                bus_data_in_d = bus_data_in;
            end
            RD_RES: bus_address_d = RES_ADDR;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous and
        // also clears the frame registers so a frame interrupted by reset leaves nothing behind.
        if (rst) begin
            state_q        <= IDLE;
            resume_q       <= IDLE;
            op_q           <= 8'd0;
            a_q            <= 8'd0;
            b_q            <= 8'd0;
            gap_cnt_q      <= 4'd0;
            cmd_ready      <= 1'b1;
            bus_address    <= 4'd0;
            bus_data_write <= 1'b0;
            bus_data_in    <= 8'd0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 8'd0;
            rsp_err        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            resume_q       <= resume_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            gap_cnt_q      <= gap_cnt_d;
            cmd_ready      <= cmd_ready_d;
            bus_address    <= bus_address_d;
            bus_data_write <= bus_data_write_d;
            bus_data_in    <= bus_data_in_d;
            rsp_valid      <= rsp_valid_d;
            rsp_data       <= rsp_data_d;
            rsp_err        <= rsp_err_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_accel_host_seq.sv
// Bench for accel_host_seq: two instances (no gap, gap of 2) each paired with a behavioural
// accelerator peripheral; results are predicted directly from (op, A, B).
module tb_accel_host_seq;

    localparam logic [3:0] RES_ADDR = 4'h5;
    localparam logic [3:0] OP_ADDR  = 4'h4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid      [2];
    logic       cmd_ready      [2];
    logic [7:0] cmd_data       [2];
    logic [3:0] bus_address    [2];
    logic       bus_data_write [2];
    logic [7:0] bus_data_in    [2];
    logic [7:0] bus_data_out   [2];
    logic       rsp_valid      [2];
    logic       rsp_ready      [2];
    logic [7:0] rsp_data       [2];
    logic       rsp_err        [2];
    logic       busy           [2];

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        int unsigned lab;
        logic [3:0]  addr;
        logic [7:0]  data;
    } wr_t;

    wr_t wlog0[$];
    wr_t wlog1[$];

    logic [7:0] preg [2][16] = '{default: '0};

    always #5 clk = ~clk;

    accel_host_seq #(.GAP_CYCLES(0), .RES_ADDR(RES_ADDR), .OP_ADDR(OP_ADDR)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_data(cmd_data[0]),
        .bus_address(bus_address[0]), .bus_data_write(bus_data_write[0]),
        .bus_data_in(bus_data_in[0]), .bus_data_out(bus_data_out[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    accel_host_seq #(.GAP_CYCLES(2), .RES_ADDR(RES_ADDR), .OP_ADDR(OP_ADDR)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_data(cmd_data[1]),
        .bus_address(bus_address[1]), .bus_data_write(bus_data_write[1]),
        .bus_data_in(bus_data_in[1]), .bus_data_out(bus_data_out[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    function automatic logic [7:0] alu(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 8'd0;
        endcase
    endfunction

    // Peripheral: registers 0 (A), 1 (B), OP_ADDR (op), RES_ADDR (result); any write
    // captures the ALU output computed from the registers as they were before the write.
    for (genvar k = 0; k < 2; k++) begin : g_per
        assign bus_data_out[k] = preg[k][bus_address[k]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (bus_data_write[k]) begin
                preg[k][RES_ADDR] <= alu(preg[k][OP_ADDR][3:0], preg[k][0], preg[k][1]);
                if (bus_address[k] != RES_ADDR) preg[k][bus_address[k]] <= bus_data_in[k];
            end
        end
    end

    function automatic wr_t mk_wr(int unsigned lab, logic [3:0] addr, logic [7:0] data);
        wr_t w;
        w.lab  = lab;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Each cycle is labelled by the value of cyc at the edge that ends it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_data_write[0]) wlog0.push_back(mk_wr(cyc, bus_address[0], bus_data_in[0]));
        if (bus_data_write[1]) wlog1.push_back(mk_wr(cyc, bus_address[1], bus_data_in[1]));
    end

    function automatic int wsize(int k);
        return (k == 0) ? wlog0.size() : wlog1.size();
    endfunction

    function automatic wr_t wget(int k, int i);
        return (k == 0) ? wlog0[i] : wlog1[i];
    endfunction

    task automatic wclear(int k);
        if (k == 0) wlog0.delete();
        else        wlog1.delete();
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(int k, logic [7:0] b);
        int t;
        t = 0;
        cmd_valid[k] = 1'b1;
        cmd_data[k]  = b;
        while (cmd_ready[k] !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("cmd_ready_for_byte", 32'(cmd_ready[k]), 32'd1);
        tick();
        cmd_valid[k] = 1'b0;
    endtask

    task automatic check_idle(int k, string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready[k]), 32'd1);
        check({tag, "_busy"}, 32'(busy[k]), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
        check({tag, "_bus_we"}, 32'(bus_data_write[k]), 32'd0);
        check({tag, "_bus_addr"}, 32'(bus_address[k]), 32'd0);
        check({tag, "_bus_din"}, 32'(bus_data_in[k]), 32'd0);
    endtask

    task automatic do_frame(int k, logic [7:0] op, logic [7:0] a, logic [7:0] b,
                            int hold, int idle);
        int          g;
        int          t;
        int unsigned n;
        logic        exp_e;
        logic [7:0]  exp_d;
        logic [7:0]  snap [16];
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
        wr_t         w;

        g     = (k == 0) ? 0 : 2;
        exp_e = (op[7:4] != 4'd0);
        exp_d = exp_e ? 8'd0 : alu(op[3:0], a, b);
        snap  = preg[k];
        wclear(k);

        send_byte(k, op);
        repeat (idle) tick();
        send_byte(k, a);
        repeat (idle) tick();
        rsp_ready[k] = (hold == 0);
        send_byte(k, b);
        n = cyc - 1;

        t = 0;
        while (rsp_valid[k] !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        check("rsp_valid_seen", 32'(rsp_valid[k]), 32'd1);
        check("rsp_latency", cyc - n, exp_e ? 32'd1 : 32'(6 + 4 * g));
        check("rsp_data", 32'(rsp_data[k]), 32'(exp_d));
        check("rsp_err", 32'(rsp_err[k]), 32'(exp_e));
        check("resp_busy", 32'(busy[k]), 32'd1);
        check("resp_cmd_ready", 32'(cmd_ready[k]), 32'd0);

        for (int i = 0; i < hold; i++) begin
            cmd_valid[k] = 1'b1;
            cmd_data[k]  = 8'hA5;
            tick();
            check("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
            check("hold_rsp_data", 32'(rsp_data[k]), 32'(exp_d));
            check("hold_rsp_err", 32'(rsp_err[k]), 32'(exp_e));
            check("hold_cmd_ready", 32'(cmd_ready[k]), 32'd0);
            check("hold_busy", 32'(busy[k]), 32'd1);
        end
        cmd_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
        check_idle(k, "after_rsp");

        check("write_count", 32'(wsize(k)), exp_e ? 32'd0 : 32'd4);
        for (int i = 0; i < 4 && i < wsize(k); i++) begin
            w = wget(k, i);
            case (i)
                0:       begin exp_addr = 4'd0;    exp_data = a; end
                1:       begin exp_addr = 4'd1;    exp_data = b; end
                default: begin exp_addr = OP_ADDR; exp_data = {4'b0, op[3:0]}; end
            endcase
            check("write_cycle", w.lab - n, 32'(1 + i * (g + 1)));
            check("write_addr", 32'(w.addr), 32'(exp_addr));
            check("write_data", 32'(w.data), 32'(exp_data));
        end
        if (exp_e) begin
            check("per_reg_a", 32'(preg[k][0]), 32'(snap[0]));
            check("per_reg_b", 32'(preg[k][1]), 32'(snap[1]));
            check("per_reg_op", 32'(preg[k][OP_ADDR]), 32'(snap[OP_ADDR]));
            check("per_reg_res", 32'(preg[k][RES_ADDR]), 32'(snap[RES_ADDR]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        logic [7:0]  op;

        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_data[k]  = 8'd0;
            rsp_ready[k] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            check_idle(k, "reset");
            check("reset_rsp_data", 32'(rsp_data[k]), 32'd0);
            check("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
        end
        rst = 1'b0;
        tick();

        do_frame(0, 8'h00, 8'h12, 8'h34, 0, 0);
        do_frame(0, 8'h01, 8'h10, 8'h30, 0, 1);
        do_frame(0, 8'h25, 8'h01, 8'h02, 0, 0);
        do_frame(0, 8'h02, 8'h5A, 8'h3C, 5, 0);

        // Reset while the opcode write is on the bus.
        wclear(0);
        send_byte(0, 8'h00);
        send_byte(0, 8'h77);
        send_byte(0, 8'h88);
        n = cyc - 1;
        tick();
        tick();
        check("wr_op_strobe", 32'(bus_data_write[0]), 32'd1);
        check("wr_op_addr", 32'(bus_address[0]), 32'(OP_ADDR));
        check("wr_op_cycle", cyc - n, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(0, "mid_reset");
        repeat (10) tick();
        check("mid_reset_writes", 32'(wsize(0)), 32'd3);
        check("mid_reset_no_rsp", 32'(rsp_valid[0]), 32'd0);
        do_frame(0, 8'h00, 8'h01, 8'h01, 0, 0);

        do_frame(1, 8'h00, 8'hFF, 8'h01, 0, 0);

        for (int i = 0; i < 16; i++) begin
            op = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255))
                                             : 8'($urandom_range(0, 4));
            do_frame(0, op, 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 5; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255))
                                             : 8'($urandom_range(0, 4));
            do_frame(1, op, 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
